// File: rtl/decodificador_pkg.sv
// Shared types and one-hot line constants for the 7-to-3 encoder / 3-to-7 decoder pair.
package decodificador_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ACTIVO = 2'd1,
    PAUSA  = 2'd2
  } estado_t;

  localparam logic [6:0] DEFECTO = 7'b0000000;
  localparam logic [6:0] UNO     = 7'b0000001;
  localparam logic [6:0] DOS     = 7'b0000010;
  localparam logic [6:0] TRES    = 7'b0000100;
  localparam logic [6:0] CUATRO  = 7'b0001000;
  localparam logic [6:0] CINCO   = 7'b0010000;
  localparam logic [6:0] SEIS    = 7'b0100000;
  localparam logic [6:0] SIETE   = 7'b1000000;

endpackage

// File: rtl/deco_3a7.sv
// Combinational 3-bit code to one-hot line; code 000 (and anything unmapped) gives DEFECTO.
module deco_3a7
  import decodificador_pkg::*;
(
  input  logic [2:0] codigo,
  output logic [6:0] linea
);

  always_comb begin
    linea = DEFECTO;
    case (codigo)
      3'b001:  linea = UNO;
      3'b010:  linea = DOS;
      3'b011:  linea = TRES;
      3'b100:  linea = CUATRO;
      3'b101:  linea = CINCO;
      3'b110:  linea = SEIS;
      3'b111:  linea = SIETE;
      default: linea = DEFECTO;
    endcase
  end

endmodule

// File: rtl/decodificador_3a7_temporizado.sv
// Timed 3-to-7 decoder: one-hot pulse of PULSO cycles per accepted code, then a 1-cycle guard gap.
// Optional DECO_REDISPARO_EN: accept codes while ACTIVO to retrigger (nonzero) or cancel (000).
module decodificador_3a7_temporizado
  import decodificador_pkg::*;
#(
  parameter int PULSO = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] Codigo,
  input  logic       Valido,
  output logic       Listo,
  output logic [6:0] Salida,
  output logic       Ocupado
);

  localparam int            CW    = (PULSO > 1) ? $clog2(PULSO) : 1;
  localparam logic [CW-1:0] CARGA = CW'(PULSO - 1);

  estado_t       estado, estado_sig;
  logic [CW-1:0] cuenta, cuenta_sig;
  logic [6:0]    salida_sig;
  logic [6:0]    linea;
  logic          acepta;

  deco_3a7 u_deco (
    .codigo (Codigo),
    .linea  (linea)
  );

`ifdef DECO_REDISPARO_EN
  assign Listo = ((estado == REPOSO) || (estado == ACTIVO)) && !rst;
`else
  assign Listo = (estado == REPOSO) && !rst;
`endif

  assign acepta  = Valido && Listo;
  assign Ocupado = (estado != REPOSO);

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= REPOSO;
      Salida <= DEFECTO;
      cuenta <= '0;
    end else begin
      estado <= estado_sig;
      Salida <= salida_sig;
      cuenta <= cuenta_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    salida_sig = Salida;
    cuenta_sig = cuenta;
    case (estado)
      REPOSO: begin
        salida_sig = DEFECTO;
        // Code 000 is consumed here without leaving REPOSO.
        if (acepta && (Codigo != 3'b000)) begin
          salida_sig = linea;
          cuenta_sig = CARGA;
          estado_sig = ACTIVO;
        end
      end
      ACTIVO: begin
`ifdef DECO_REDISPARO_EN
        if (acepta) begin
          if (Codigo != 3'b000) begin
            salida_sig = linea;
            cuenta_sig = CARGA;
          end else begin
            salida_sig = DEFECTO;
            estado_sig = PAUSA;
          end
        end else
`endif
        if (cuenta != '0) begin
          cuenta_sig = cuenta - 1'b1;
        end else begin
          salida_sig = DEFECTO;
          estado_sig = PAUSA;
        end
      end
      PAUSA: begin
        salida_sig = DEFECTO;
        estado_sig = REPOSO;
      end
      default: begin
        salida_sig = DEFECTO;
        estado_sig = REPOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_decodificador_3a7_temporizado.sv
// Self-checking bench for decodificador_3a7_temporizado; per-cycle expectations queued at stimulus time.
module tb_decodificador_3a7_temporizado;

  localparam int PULSO = 4;
`ifdef DECO_REDISPARO_EN
  localparam logic ACT_LI = 1'b1;
`else
  localparam logic ACT_LI = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] Codigo;
  logic       Valido;
  logic       Listo;
  logic [6:0] Salida;
  logic       Ocupado;

  decodificador_3a7_temporizado #(.PULSO(PULSO)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .Codigo  (Codigo),
    .Valido  (Valido),
    .Listo   (Listo),
    .Salida  (Salida),
    .Ocupado (Ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] s;
    logic       oc;
    logic       li;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t idle;
  int   checks;
  int   failures;

  function automatic logic [6:0] oh(input int c);
    logic [6:0] v;
    v = 7'd1 << (c - 1);
    return v;
  endfunction

  task automatic push_pulse(input logic [6:0] s);
    for (int i = 0; i < PULSO; i++) q.push_back('{s, 1'b1, ACT_LI});
    q.push_back('{7'd0, 1'b1, 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1; Valido = 1'b0; Codigo = 3'b000;
    repeat (2) @(negedge clk);
    checks++;
    if (Salida !== 7'd0 || Ocupado !== 1'b0 || Listo !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold Salida=%b Ocupado=%b Listo=%b expected 0000000 0 0", Salida, Ocupado, Listo);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (Listo !== 1'b1 || Ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reset_release Listo=%b Ocupado=%b expected 1 0", Listo, Ocupado);
    end
  endtask

  task automatic test_single();
    Codigo = 3'b011; Valido = 1'b1;
    push_pulse(oh(3));
    for (int i = 0; i < PULSO + 3; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL single cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Valido = 1'b0;
    end
  endtask

  task automatic test_sweep();
    for (int c = 1; c <= 7; c++) begin
      Codigo = 3'(c); Valido = 1'b1;
      push_pulse(oh(c));
      for (int i = 0; i < PULSO + 2; i++) begin
        @(negedge clk);
        if (q.size() > 0) e = q.pop_front(); else e = idle;
        checks++;
        if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
          failures++;
          $display("FAIL sweep code=%0d cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", c, i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
        end
      end
    end
    Valido = 1'b0;
  endtask

  task automatic test_cero();
    Codigo = 3'b000; Valido = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL cero cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
    end
    Valido = 1'b0;
  endtask

  task automatic test_reset_activo();
    Codigo = 3'b101; Valido = 1'b1;
    push_pulse(oh(5));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL rst_activo cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Valido = 1'b0;
      if (i == 1) rst = 1'b1;
    end
    q.delete();
    @(negedge clk);
    checks++;
    if (Salida !== 7'd0 || Ocupado !== 1'b0 || Listo !== 1'b0) begin
      failures++;
      $display("FAIL rst_activo_clear Salida=%b Ocupado=%b Listo=%b expected 0000000 0 0", Salida, Ocupado, Listo);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (Listo !== 1'b1 || Salida !== 7'd0) begin
      failures++;
      $display("FAIL rst_activo_release Listo=%b Salida=%b expected 1 0000000", Listo, Salida);
    end
  endtask

  task automatic test_ignorado();
    Codigo = 3'b001; Valido = 1'b1;
    push_pulse(oh(1));
    for (int i = 0; i < PULSO + 2; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL ignorado cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Codigo = 3'b111;
      if (i == PULSO + 1) push_pulse(oh(7));
    end
    for (int i = 0; i < PULSO + 2; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL ignorado_late cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Valido = 1'b0;
    end
  endtask

  task automatic test_redisparo();
    Codigo = 3'b010; Valido = 1'b1;
    q.push_back('{oh(2), 1'b1, ACT_LI});
    q.push_back('{oh(2), 1'b1, ACT_LI});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL redisparo_a cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Valido = 1'b0;
      if (i == 1) begin
        Codigo = 3'b110; Valido = 1'b1;
        push_pulse(oh(6));
      end
    end
    for (int i = 0; i < PULSO + 2; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL redisparo_b cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Valido = 1'b0;
    end
    Codigo = 3'b100; Valido = 1'b1;
    q.push_back('{oh(4), 1'b1, ACT_LI});
    q.push_back('{7'd0, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (q.size() > 0) e = q.pop_front(); else e = idle;
      checks++;
      if (Salida !== e.s || Ocupado !== e.oc || Listo !== e.li) begin
        failures++;
        $display("FAIL cancel cyc=%0d Salida=%b Ocupado=%b Listo=%b expected %b %b %b", i, Salida, Ocupado, Listo, e.s, e.oc, e.li);
      end
      if (i == 0) Codigo = 3'b000;
      if (i == 1) Valido = 1'b0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle     = '{7'd0, 1'b0, 1'b1};
    test_reset();
    test_single();
    test_cero();
    test_reset_activo();
`ifdef DECO_REDISPARO_EN
    test_redisparo();
`else
    test_sweep();
    test_ignorado();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
